// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
// Holds the state encoding, the power-on init byte table and command codes.
// Imported by the controller top and its timer.
package lcd_pkg;

  localparam int TMR_W = 20;

  typedef enum logic [2:0] {
    ST_PWR_WAIT  = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_EXEC_WAIT = 3'd5,
    ST_IDLE      = 3'd6
  } state_t;

  // 8-bit power-on initialisation sequence
  localparam int         INIT_LEN = 6;
  localparam logic [7:0] INIT_B0  = 8'h38;  // function set, 8-bit, 2 lines
  localparam logic [7:0] INIT_B1  = 8'h38;
  localparam logic [7:0] INIT_B2  = 8'h38;
  localparam logic [7:0] INIT_B3  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] INIT_B4  = 8'h01;  // clear display
  localparam logic [7:0] INIT_B5  = 8'h06;  // entry mode, increment

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return INIT_B0;
      3'd1:    return INIT_B1;
      3'd2:    return INIT_B2;
      3'd3:    return INIT_B3;
      3'd4:    return INIT_B4;
      3'd5:    return INIT_B5;
      default: return 8'h00;
    endcase
  endfunction

  // Clear, home and 0x00 all need the long execution wait
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] dat);
    return !rs && (dat[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable 20-bit down-counter; done is high while the count sits at zero.
// Latency: a load takes effect on the next edge, then counts one per cycle.
// No backpressure: load always wins over counting.
module lcd_timer
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 controller: power-on init, then single-byte writes with setup/enable/hold/exec timing.
// Latency: E0 load, lcd_en at E0+SETUP for PULSE cycles, ready back at E0+SETUP+PULSE+HOLD+exec wait.
// Backpressure: ready is high only in IDLE; requests held by the requester until accepted, never queued.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC = 750000,
  parameter int SETUP_CYC   = 4,
  parameter int PULSE_CYC   = 12,
  parameter int HOLD_CYC    = 2,
  parameter int CMD_CYC     = 2500,
  parameter int CLR_CYC     = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  // Timer reload values: a state lasting N cycles loads N-1
  localparam logic [TMR_W-1:0] PWR_M2   = TMR_W'((POWERUP_CYC > 1) ? POWERUP_CYC - 2 : 0);
  localparam logic [TMR_W-1:0] SETUP_M1 = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_M1 = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_M1  = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] CMD_L    = TMR_W'(CMD_CYC);
  localparam logic [TMR_W-1:0] CLR_L    = TMR_W'(CLR_CYC);

  state_t           state;
  logic [2:0]       idx;
  logic             pwr_arm;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;
  logic [TMR_W-1:0] exec_cyc;
  logic             init_more;

  assign lcd_rw = 1'b0;

  // Exec wait is chosen from the byte currently on the bus
  assign exec_cyc  = is_slow_cmd(lcd_rs, lcd_data) ? CLR_L : CMD_L;
  assign init_more = !init_done && (idx != 3'(INIT_LEN - 1));

  lcd_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Timer reloads on every state entry; the init path gives up one exec cycle to INIT_LOAD
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_PWR_WAIT: begin
        if (!pwr_arm) begin
          tmr_load = 1'b1;
          tmr_val  = PWR_M2;
        end
      end
      ST_INIT_LOAD: begin
        tmr_load = 1'b1;
        tmr_val  = SETUP_M1;
      end
      ST_IDLE: begin
        if (req_valid) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_M1;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_M1;
        end
      end
      ST_PULSE: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_M1;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = init_more ? (exec_cyc - TMR_W'(2)) : (exec_cyc - TMR_W'(1));
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  // Sequencer: power-up wait, init writes, then handshaked user writes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PWR_WAIT;
      idx       <= 3'd0;
      pwr_arm   <= 1'b0;
      ready     <= 1'b0;
      init_done <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      case (state)
        ST_PWR_WAIT: begin
          if (!pwr_arm) begin
            pwr_arm <= 1'b1;
            if (POWERUP_CYC == 1) state <= ST_INIT_LOAD;
          end else if (tmr_done) begin
            state <= ST_INIT_LOAD;
          end
        end
        ST_INIT_LOAD: begin
          lcd_rs   <= 1'b0;
          lcd_data <= init_byte(idx);
          state    <= ST_SETUP;
        end
        ST_IDLE: begin
          if (req_valid) begin
            ready    <= 1'b0;
            lcd_rs   <= req_rs;
            lcd_data <= req_data;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            lcd_en <= 1'b1;
            state  <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (tmr_done) begin
            lcd_en <= 1'b0;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            if (init_more && (exec_cyc == TMR_W'(1))) begin
              idx   <= idx + 3'd1;
              state <= ST_INIT_LOAD;
            end else begin
              state <= ST_EXEC_WAIT;
            end
          end
        end
        ST_EXEC_WAIT: begin
          if (tmr_done) begin
            if (init_more) begin
              idx   <= idx + 3'd1;
              state <= ST_INIT_LOAD;
            end else begin
              state     <= ST_IDLE;
              ready     <= 1'b1;
              init_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_PWR_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: timing model by edge arithmetic, per-cycle pin compare, directed and random writes.
module tb_lcd_ctrl;

  localparam int PU  = 20;
  localparam int S   = 2;
  localparam int P   = 3;
  localparam int H   = 1;
  localparam int CMD = 5;
  localparam int CLR = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       ready, init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  lcd_ctrl #(
    .POWERUP_CYC (PU),
    .SETUP_CYC   (S),
    .PULSE_CYC   (P),
    .HOLD_CYC    (H),
    .CMD_CYC     (CMD),
    .CLR_CYC     (CLR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .ready     (ready),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int rst_edge = 0;
  bit model_on = 1'b0;

  logic [7:0] init_tab [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Model: each write is a start edge plus fixed offsets
  int         m_e0 = -1000;
  int         m_next = 0;
  int         m_writes = 0;
  bit         m_ready = 1'b0;
  bit         m_done = 1'b0;
  bit         m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;

  function automatic int exec_of(input bit rs, input logic [7:0] d);
    return (!rs && d < 8'h04) ? CLR : CMD;
  endfunction

  initial forever begin
    @(posedge clk);
    edge_n = edge_n + 1;
    if (rst) begin
      model_on = 1'b1;
      rst_edge = edge_n;
      m_next   = edge_n + 1 + PU;
      m_writes = 0;
      m_ready  = 1'b0;
      m_done   = 1'b0;
      m_rs     = 1'b0;
      m_data   = 8'h00;
      m_e0     = -1000;
    end else if (model_on) begin
      if (!m_done) begin
        if (edge_n == m_next) begin
          if (m_writes < 6) begin
            m_rs     = 1'b0;
            m_data   = init_tab[m_writes];
            m_e0     = edge_n;
            m_next   = edge_n + S + P + H + exec_of(1'b0, m_data);
            m_writes = m_writes + 1;
          end else begin
            m_done  = 1'b1;
            m_ready = 1'b1;
          end
        end
      end else if (m_ready) begin
        if (req_valid) begin
          m_rs    = req_rs;
          m_data  = req_data;
          m_e0    = edge_n;
          m_next  = edge_n + S + P + H + exec_of(req_rs, req_data);
          m_ready = 1'b0;
        end
      end else if (edge_n == m_next) begin
        m_ready = 1'b1;
      end
    end
  end

  // Pulse log filled by the monitor
  logic [8:0] pulse_dat [$];
  int         pulse_w [$];
  int         pulse_rise [$];
  int         en_rise_e = 0;
  int         en_fall_e = 0;
  int         cur_w = 0;
  bit         prev_en = 1'b0;

  // Compare every cycle against the model, and log lcd_en pulses
  initial forever begin
    logic [12:0] exp_v, got_v;
    bit          exp_en;
    @(negedge clk);
    if (model_on) begin
      exp_en = (edge_n >= m_e0 + S) && (edge_n < m_e0 + S + P);
      exp_v  = {m_ready, m_done, m_rs, 1'b0, exp_en, m_data};
      got_v  = {ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_data};
      checks = checks + 1;
      if (got_v !== exp_v) begin
        errors = errors + 1;
        $display("FAIL pins edge %0d: got rdy/done/rs/rw/en/data=%b want %b", edge_n, got_v, exp_v);
      end
      if (lcd_en && !prev_en) begin
        en_rise_e = edge_n;
        cur_w = 0;
      end
      if (lcd_en) cur_w = cur_w + 1;
      if (!lcd_en && prev_en) begin
        en_fall_e = edge_n;
        pulse_dat.push_back({lcd_rs, lcd_data});
        pulse_w.push_back(cur_w);
        pulse_rise.push_back(en_rise_e);
      end
      prev_en = lcd_en;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk({name, " ready timeout"}, 0, 1);
  endtask

  task automatic send(input bit rs, input logic [7:0] d, output int acc);
    wait_ready("send");
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    acc       = edge_n + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " init_done"}, int'(init_done), 1);
    chk({name, " ready with init_done"}, int'(ready), 1);
  endtask

  task automatic check_init_pulses(input string name, input int base);
    chk({name, " pulse count"}, pulse_dat.size() - base, 6);
    if (pulse_dat.size() - base >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("%s byte %0d", name, i), int'(pulse_dat[base+i]), int'({1'b0, init_tab[i]}));
        chk($sformatf("%s width %0d", name, i), pulse_w[base+i], 3);
      end
      chk({name, " gap 0C->01"}, pulse_rise[base+4] - pulse_rise[base+3], 11);
      chk({name, " gap 01->06"}, pulse_rise[base+5] - pulse_rise[base+4], 16);
      chk({name, " first en rise"}, pulse_rise[base] - rst_edge, 23);
    end
  endtask

  initial begin
    int acc, acc2, r, base, n;
    bit          rs;
    logic [7:0]  d;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset ready", int'(ready), 0);
    chk("reset init_done", int'(init_done), 0);
    chk("reset lcd_en", int'(lcd_en), 0);
    chk("reset lcd_data", int'(lcd_data), 0);

    wait_init("boot");
    check_init_pulses("boot", 0);

    // Data write 0x41
    send(1'b1, 8'h41, acc);
    wait_ready("data");
    r = edge_n;
    chk("data en rise", en_rise_e - acc, 2);
    chk("data en fall", en_fall_e - acc, 5);
    chk("data ready back", r - acc, 11);
    chk("data pulse byte", int'(pulse_dat[$]), 9'h141);

    // Clear command takes the long wait, set-address the short one
    send(1'b0, 8'h01, acc);
    wait_ready("clr");
    chk("clear ready back", edge_n - acc, 16);
    send(1'b0, 8'h80, acc);
    wait_ready("ddram");
    chk("0x80 ready back", edge_n - acc, 11);

    // Back-to-back with req_valid held
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h41;
    acc       = edge_n + 1;
    @(negedge clk);
    req_data  = 8'h42;
    wait_ready("b2b");
    r    = edge_n;
    acc2 = r + 1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready("b2b2");
    chk("b2b first ready", r - acc, 11);
    chk("b2b second en rise", en_rise_e - acc2, 2);
    chk("b2b second byte", int'(pulse_dat[$]), 9'h142);
    chk("b2b second ready", edge_n - acc2, 11);

    // Request pulse while busy is ignored
    base = pulse_dat.size();
    send(1'b0, 8'h80, acc);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 8'h55;
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready("busy");
    chk("busy pulse count", pulse_dat.size() - base, 1);

    // Random writes, some with ignored busy requests
    for (int k = 0; k < 40; k++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rs, d, acc);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 1'b1;
        req_data  = 8'($urandom_range(0, 255));
        @(negedge clk);
        req_valid = 1'b0;
      end
    end
    wait_ready("random end");

    // Reset in the middle of an enable pulse
    send(1'b1, 8'h5A, acc);
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midpulse en seen", int'(lcd_en), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset lcd_en", int'(lcd_en), 0);
    chk("midreset ready", int'(ready), 0);
    chk("midreset init_done", int'(init_done), 0);
    @(negedge clk);
    @(negedge clk);
    base = pulse_dat.size();
    wait_init("reinit");
    check_init_pulses("reinit", base);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
